cpu_ctl_seq: RTL and testbench

//  Parametrised control sequencer for the RISC CPU core, successor to the fixed 8-phase controller.

---
 rtl/cpu_ctl_pkg.sv | 45 ++++
 rtl/cpu_mem_wait_tmr.sv | 29 ++
 rtl/cpu_ctl_seq.sv | 161 ++++++++++++++++
 tb/tb_cpu_ctl_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctl_pkg.sv
// rtl/cpu_ctl_pkg.sv - opcodes, state encoding and decode helpers for the CPU control sequencer
package cpu_ctl_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FINC,
    S_DECODE,
    S_MRD,
    S_WB,
    S_WSU,
    S_MWR,
    S_WHD,
    S_JMP,
    S_SKIP,
    S_HALTED
  } state_e;

  // States that wait on mem_rdy and are guarded by the timeout counter.
  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MRD) || (s == S_MWR);
  endfunction

  function automatic state_e decode_next(logic [2:0] op, logic z);
    state_e s;
    case (op)
      OP_HLT:                         s = S_HALTED;
      OP_SKZ:                         s = z ? S_SKIP : S_FETCH;
      OP_ADD, OP_AND, OP_XOR, OP_LDA: s = S_MRD;
      OP_STO:                         s = S_WSU;
      default:                        s = S_JMP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cpu_mem_wait_tmr.sv
// rtl/cpu_mem_wait_tmr.sv - saturating mem_rdy wait counter with timeout compare
module cpu_mem_wait_tmr #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] SAT = CW'(WAIT_MAX);
  localparam logic [CW-1:0] LIM = CW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && (cnt != SAT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires during the WAIT_MAX-th not-ready cycle; a ready in that cycle drops en and wins.
  assign expired = (WAIT_MAX > 0) && en && (cnt == LIM);

endmodule

// File: rtl/cpu_ctl_seq.sv
// rtl/cpu_ctl_seq.sv - CPU control sequencer with wait states, multi-beat fetch and halt/resume
module cpu_ctl_seq
  import cpu_ctl_pkg::*;
#(
  parameter int OPW      = 3,
  parameter int IR_BEATS = 2,
  parameter int WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           fetch,
  input  logic           resume,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_rdy,
  output logic           inc_pc,
  output logic           load_acc,
  output logic           load_pc,
  output logic           load_ir,
  output logic           rd,
  output logic           wr,
  output logic           datactl_ena,
  output logic           halt,
  output logic           illegal_op,
  output logic           bus_err,
  output logic           busy
);

  localparam logic [1:0] LAST_BEAT = 2'(IR_BEATS - 1);

  state_e     state, state_n;
  logic [1:0] beat, beat_n;
  logic       last_beat, illegal, in_wait, expired;
  logic       ill_n, berr_n;
  logic       inc_pc_n, load_acc_n, load_pc_n, load_ir_n, rd_n, wr_n, dc_n, halt_n, busy_n;

  assign last_beat = (beat >= LAST_BEAT);
  assign illegal   = (OPW > 3) && (opcode > OPW'(7));
  assign in_wait   = is_wait_state(state);

  cpu_mem_wait_tmr #(.WAIT_MAX(WAIT_MAX)) u_wait_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_wait),
    .en      (in_wait && !mem_rdy),
    .expired (expired)
  );

  always_comb begin
    state_n = state;
    beat_n  = beat;
    ill_n   = 1'b0;
    berr_n  = 1'b0;
    case (state)
      S_IDLE: if (fetch) begin
        state_n = S_FETCH;
        beat_n  = '0;
      end
      S_FETCH: begin
        if (mem_rdy) state_n = S_FINC;
        else if (expired) begin
          state_n = S_HALTED;
          berr_n  = 1'b1;
        end
      end
      S_FINC: begin
        if (!last_beat) begin
          state_n = S_FETCH;
          beat_n  = beat + 2'd1;
        end else begin
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        beat_n = '0;
        if (illegal) begin
          state_n = S_FETCH;
          ill_n   = 1'b1;
        end else begin
          state_n = decode_next(opcode[2:0], zero);
        end
      end
      S_MRD: begin
        if (mem_rdy) state_n = S_WB;
        else if (expired) begin
          state_n = S_HALTED;
          berr_n  = 1'b1;
        end
      end
      S_WSU: state_n = S_MWR;
      S_MWR: begin
        if (mem_rdy) state_n = S_WHD;
        else if (expired) begin
          state_n = S_HALTED;
          berr_n  = 1'b1;
        end
      end
      S_WB, S_WHD, S_JMP: state_n = S_FETCH;
      // beat is reused to count the IR_BEATS skip increments
      S_SKIP: begin
        if (!last_beat) begin
          beat_n = beat + 2'd1;
        end else begin
          state_n = S_FETCH;
          beat_n  = '0;
        end
      end
      S_HALTED: if (resume) begin
        state_n = S_FETCH;
        beat_n  = '0;
      end
      default: begin
        state_n = S_IDLE;
        beat_n  = '0;
      end
    endcase

    rd_n       = (state_n == S_FETCH) || (state_n == S_MRD);
    load_ir_n  = (state_n == S_FETCH);
    inc_pc_n   = (state_n == S_FINC) || (state_n == S_SKIP);
    load_acc_n = (state_n == S_WB);
    load_pc_n  = (state_n == S_JMP);
    wr_n       = (state_n == S_MWR);
    dc_n       = (state_n == S_WSU) || (state_n == S_MWR) || (state_n == S_WHD);
    halt_n     = (state_n == S_HALTED);
    busy_n     = (state_n != S_IDLE) && (state_n != S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      beat        <= '0;
      inc_pc      <= 1'b0;
      load_acc    <= 1'b0;
      load_pc     <= 1'b0;
      load_ir     <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      datactl_ena <= 1'b0;
      halt        <= 1'b0;
      illegal_op  <= 1'b0;
      bus_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      beat        <= beat_n;
      inc_pc      <= inc_pc_n;
      load_acc    <= load_acc_n;
      load_pc     <= load_pc_n;
      load_ir     <= load_ir_n;
      rd          <= rd_n;
      wr          <= wr_n;
      datactl_ena <= dc_n;
      halt        <= halt_n;
      illegal_op  <= ill_n;
      bus_err     <= berr_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_cpu_ctl_seq.sv
// tb/tb_cpu_ctl_seq.sv - randomized instruction-level bench for cpu_ctl_seq
module tb_cpu_ctl_seq;

  localparam int OPW = 4;
  localparam int IRB = 2;
  localparam int WM  = 15;

  localparam logic [10:0] INC  = 11'h400;
  localparam logic [10:0] LACC = 11'h200;
  localparam logic [10:0] LPC  = 11'h100;
  localparam logic [10:0] LIR  = 11'h080;
  localparam logic [10:0] RD   = 11'h040;
  localparam logic [10:0] WR   = 11'h020;
  localparam logic [10:0] DC   = 11'h010;
  localparam logic [10:0] HLT  = 11'h008;
  localparam logic [10:0] ILL  = 11'h004;
  localparam logic [10:0] BERR = 11'h002;
  localparam logic [10:0] BSY  = 11'h001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fetch = 1'b0;
  logic resume = 1'b0;
  logic zero = 1'b0;
  logic mem_rdy = 1'b0;
  logic [OPW-1:0] opcode = '0;
  logic inc_pc, load_acc, load_pc, load_ir, rd, wr, datactl_ena, halt, illegal_op, bus_err, busy;
  logic [10:0] obs;

  always #5 clk = ~clk;

  cpu_ctl_seq #(.OPW(OPW), .IR_BEATS(IRB), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n), .fetch(fetch), .resume(resume), .opcode(opcode),
    .zero(zero), .mem_rdy(mem_rdy), .inc_pc(inc_pc), .load_acc(load_acc),
    .load_pc(load_pc), .load_ir(load_ir), .rd(rd), .wr(wr), .datactl_ena(datactl_ena),
    .halt(halt), .illegal_op(illegal_op), .bus_err(bus_err), .busy(busy)
  );

  assign obs = {inc_pc, load_acc, load_pc, load_ir, rd, wr, datactl_ena,
                halt, illegal_op, bus_err, busy};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int force_w = -1;
  logic pend_ill  = 1'b0;
  logic pend_berr = 1'b0;
  logic [10:0] e_q[$];
  logic [7:0]  s_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle of expectation plus the inputs driven during that cycle.
  task automatic push_all(input logic [10:0] e, input logic rdy, input logic res,
                          input logic fet, input logic [3:0] op, input logic z);
    e_q.push_back(e | (pend_ill ? ILL : 11'h0) | (pend_berr ? BERR : 11'h0));
    pend_ill  = 1'b0;
    pend_berr = 1'b0;
    s_q.push_back({rdy, res, fet, z, op});
  endtask

  task automatic push(input logic [10:0] e, input logic rdy);
    push_all(e, rdy, 1'($urandom % 2), 1'($urandom % 2), 4'($urandom), 1'($urandom % 2));
  endtask

  task automatic seg_halt();
    int n;
    n = 1 + int'($urandom % 3);
    for (int i = 0; i < n; i++)
      push_all(HLT, 1'($urandom % 2), (i == n - 1), 1'($urandom % 2), 4'($urandom), 1'($urandom % 2));
  endtask

  task automatic seg_wait(input logic [10:0] e, output bit to);
    int w, r;
    r = int'($urandom % 16);
    if (force_w >= 0) w = force_w;
    else w = (r < 10) ? 0 : (r < 14) ? 1 + int'($urandom % 3) : (r == 14) ? WM - 1 : WM;
    if (w >= WM) begin
      for (int i = 0; i < WM; i++) push(e, 1'b0);
      pend_berr = 1'b1;
      seg_halt();
      to = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) push(e, 1'b0);
      push(e, 1'b1);
      to = 1'b0;
    end
  endtask

  task automatic seg_fetch(output bit to);
    to = 1'b0;
    for (int b = 0; b < IRB; b++) begin
      seg_wait(RD | LIR | BSY, to);
      if (to) return;
      push(INC | BSY, 1'($urandom % 2));
    end
  endtask

  task automatic gen_instr(input int op_sel, input int z_sel);
    bit to;
    int op;
    logic z;
    seg_fetch(to);
    if (to) return;
    if (op_sel >= 0) op = op_sel;
    else begin
      op = int'($urandom % 10);
      if (op > 7) op = 8 + int'($urandom % 8);
    end
    z = (z_sel >= 0) ? 1'(z_sel) : 1'($urandom % 2);
    push_all(BSY, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 4'(op), z);
    if (op > 7) pend_ill = 1'b1;
    else case (op)
      0: seg_halt();
      1: if (z) for (int i = 0; i < IRB; i++) push(INC | BSY, 1'($urandom % 2));
      2, 3, 4, 5: begin
        seg_wait(RD | BSY, to);
        if (!to) push(LACC | BSY, 1'($urandom % 2));
      end
      6: begin
        push(DC | BSY, 1'($urandom % 2));
        seg_wait(WR | DC | BSY, to);
        if (!to) push(DC | BSY, 1'($urandom % 2));
      end
      default: push(LPC | BSY, 1'($urandom % 2));
    endcase
  endtask

  task automatic play();
    logic [10:0] e;
    logic [7:0]  s;
    while (e_q.size() > 0) begin
      e = e_q.pop_front();
      s = s_q.pop_front();
      @(posedge clk);
      #1;
      {mem_rdy, resume, fetch, zero, opcode} = s;
      @(negedge clk);
      check($sformatf("cyc%0d", cyc), {5'b0, obs}, {5'b0, e});
      cyc++;
    end
  endtask

  initial begin
    bit to;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", {5'b0, obs}, 16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) push_all(11'h0, 1'($urandom % 2), 1'($urandom % 2), 1'b0, 4'($urandom), 1'b0);
    push_all(11'h0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    force_w = 0;
    seg_fetch(to);
    push_all(BSY, 1'b1, 1'b0, 1'b0, 4'd6, 1'b0);
    push(DC | BSY, 1'b1);
    for (int i = 0; i < 3; i++) push(WR | DC | BSY, 1'b0);
    play();

    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    mem_rdy = 1'b0;
    @(negedge clk);
    check("mwr_pre_rst", {5'b0, obs}, {5'b0, WR | DC | BSY});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fetch = 1'b0;
    @(negedge clk);
    check("rst_mwr", {5'b0, obs}, 16'h0);

    push_all(11'h0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    force_w = 0;
    gen_instr(7, -1);
    gen_instr(5, -1);
    gen_instr(6, -1);
    gen_instr(1, 1);
    gen_instr(1, 0);
    gen_instr(0, -1);
    gen_instr(2, -1);
    gen_instr(3, -1);
    gen_instr(4, -1);
    gen_instr(9, -1);
    force_w = 3;
    gen_instr(5, -1);
    force_w = WM - 1;
    gen_instr(7, -1);
    force_w = WM;
    gen_instr(7, -1);
    force_w = -1;
    play();

    for (int k = 0; k < 300; k++) begin
      gen_instr(-1, -1);
      play();
    end
    force_w = 0;
    seg_fetch(to);
    play();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
